// File: rtl/bg_frame_scheduler.sv
// bg_frame_scheduler: runs an array of background-removal PEs through one frame.
// Sum phase (start, wait for all SUM_DONE, ack), reduction of the per-PE colour
// sums to the expected background RGB, then the removal phase (start, wait for
// all BG_DONE, ack) and a one-cycle Done pulse.
// Optional feature macro: BGS_WATCHDOG_EN adds a wait-state watchdog that sets
// a sticky Error flag, pulses Ack once and abandons the frame without Done.
// Assumes SUM_W >= 8 so the averaged value can be saturated to 8 bits.
module bg_frame_scheduler #(
   parameter int NUM_PE      = 4,
   parameter int LOG2_PIX    = 2,
   parameter int SUM_W       = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                    Clk,
   input  logic                    Reset_n,
   input  logic                    Go,
   input  logic                    Skip_Sum,
   input  logic [NUM_PE-1:0]       Pe_Qsd,
   input  logic [NUM_PE-1:0]       Pe_Qbgd,
   input  logic [NUM_PE*SUM_W-1:0] Pe_Red_Sum,
   input  logic [NUM_PE*SUM_W-1:0] Pe_Green_Sum,
   input  logic [NUM_PE*SUM_W-1:0] Pe_Blue_Sum,
   output logic                    Start_Sum,
   output logic                    Start_BgRemoval,
   output logic                    Ack,
   output logic [7:0]              Red_Exp,
   output logic [7:0]              Green_Exp,
   output logic [7:0]              Blue_Exp,
   output logic                    Busy,
   output logic                    Done,
   output logic                    Error
);

   // index needs at least one bit even for a single PE
   localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   // accumulator wide enough that NUM_PE full-scale sums cannot overflow
   localparam int ACC_W = SUM_W + IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

   typedef enum logic [3:0] {
      IDLE, S_START, S_WAIT, S_ACK, REDUCE, AVG, B_START, B_WAIT, B_ACK, FIN
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic             w_start_sum;
   logic             w_start_bg;
   logic             w_ack;
   logic             w_done;
   logic             w_timeout;
   logic             w_wd_fire;
   logic             r_abort;
   logic             r_error;

   logic [IDX_W-1:0] r_idx;
   logic [ACC_W-1:0] r_red_acc;
   logic [ACC_W-1:0] r_green_acc;
   logic [ACC_W-1:0] r_blue_acc;
   logic [7:0]       r_red_exp;
   logic [7:0]       r_green_exp;
   logic [7:0]       r_blue_exp;

   logic [SUM_W-1:0] w_red_pe   [NUM_PE];
   logic [SUM_W-1:0] w_green_pe [NUM_PE];
   logic [SUM_W-1:0] w_blue_pe  [NUM_PE];
   logic [SUM_W-1:0] w_red_sel;
   logic [SUM_W-1:0] w_green_sel;
   logic [SUM_W-1:0] w_blue_sel;

   // unpack the flat per-PE sum buses into arrays indexed by PE number
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PE; gi++) begin : g_unpack
         assign w_red_pe[gi]   = Pe_Red_Sum[gi*SUM_W +: SUM_W];
         assign w_green_pe[gi] = Pe_Green_Sum[gi*SUM_W +: SUM_W];
         assign w_blue_pe[gi]  = Pe_Blue_Sum[gi*SUM_W +: SUM_W];
      end
   endgenerate

   assign w_red_sel   = w_red_pe[r_idx];
   assign w_green_sel = w_green_pe[r_idx];
   assign w_blue_sel  = w_blue_pe[r_idx];

   // a zero timeout would abort every wait immediately; reject it at elaboration
   generate
      if (TIMEOUT_CYC < 1) begin : g_bad_timeout
         bad_parameter_timeout_cyc_must_be_positive u_bad ();
      end
   endgenerate

`ifdef BGS_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   logic [WD_W-1:0] r_wd_cnt;
   logic            w_in_wait;

   assign w_in_wait = (r_state == S_WAIT) || (r_state == B_WAIT);
   assign w_timeout = w_in_wait && (r_wd_cnt == WD_LAST);

   // cycle counter: zero outside the wait states, counts while waiting
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_wd_cnt <= '0;
      end else if (w_in_wait) begin
         r_wd_cnt <= r_wd_cnt + 1'b1;
      end else begin
         r_wd_cnt <= '0;
      end
   end

   // sticky error flag, cleared only by reset
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_error <= 1'b0;
      end else if (w_wd_fire) begin
         r_error <= 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;

   // no watchdog: the error flag never sets
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_error <= 1'b0;
      end else begin
         r_error <= 1'b0;
      end
   end
`endif

   // state register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // next-state and pulse decode; completion wins over a same-cycle timeout
   always_comb begin
      w_state_next = r_state;
      w_start_sum  = 1'b0;
      w_start_bg   = 1'b0;
      w_ack        = 1'b0;
      w_done       = 1'b0;
      w_wd_fire    = 1'b0;
      case (r_state)
         IDLE: begin
            if (Go) begin
               w_state_next = Skip_Sum ? B_START : S_START;
            end
         end
         S_START: begin
            w_start_sum  = 1'b1;
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (&Pe_Qsd) begin
               w_state_next = S_ACK;
            end else if (w_timeout) begin
               w_wd_fire    = 1'b1;
               w_state_next = B_ACK;
            end
         end
         S_ACK: begin
            w_ack        = 1'b1;
            w_state_next = REDUCE;
         end
         REDUCE: begin
            if (r_idx == LAST_IDX) begin
               w_state_next = AVG;
            end
         end
         AVG: begin
            w_state_next = B_START;
         end
         B_START: begin
            w_start_bg   = 1'b1;
            w_state_next = B_WAIT;
         end
         B_WAIT: begin
            if (&Pe_Qbgd) begin
               w_state_next = B_ACK;
            end else if (w_timeout) begin
               w_wd_fire    = 1'b1;
               w_state_next = B_ACK;
            end
         end
         B_ACK: begin
            w_ack        = 1'b1;
            w_state_next = r_abort ? IDLE : FIN;
         end
         FIN: begin
            w_done       = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // remembers that the pending B_ACK ends an abandoned frame (no Done)
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_abort <= 1'b0;
      end else if (w_wd_fire) begin
         r_abort <= 1'b1;
      end else if (r_state == B_ACK) begin
         r_abort <= 1'b0;
      end
   end

   // divide by the pixel count and clamp to the 8-bit colour range
   function automatic logic [7:0] sat_avg(input logic [ACC_W-1:0] acc);
      logic [ACC_W-1:0] shifted;
      shifted = acc >> LOG2_PIX;
      if (shifted > ACC_W'(255)) begin
         return 8'hFF;
      end
      return shifted[7:0];
   endfunction

   // reduction datapath: one PE per cycle, then latch the averaged colours
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_idx       <= '0;
         r_red_acc   <= '0;
         r_green_acc <= '0;
         r_blue_acc  <= '0;
         r_red_exp   <= '0;
         r_green_exp <= '0;
         r_blue_exp  <= '0;
      end else begin
         case (r_state)
            S_ACK: begin
               r_idx       <= '0;
               r_red_acc   <= '0;
               r_green_acc <= '0;
               r_blue_acc  <= '0;
            end
            REDUCE: begin
               r_red_acc   <= r_red_acc   + ACC_W'(w_red_sel);
               r_green_acc <= r_green_acc + ACC_W'(w_green_sel);
               r_blue_acc  <= r_blue_acc  + ACC_W'(w_blue_sel);
               if (r_idx != LAST_IDX) begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            AVG: begin
               r_red_exp   <= sat_avg(r_red_acc);
               r_green_exp <= sat_avg(r_green_acc);
               r_blue_exp  <= sat_avg(r_blue_acc);
            end
            default: begin
            end
         endcase
      end
   end

   assign Start_Sum       = w_start_sum;
   assign Start_BgRemoval = w_start_bg;
   assign Ack             = w_ack;
   assign Done            = w_done;
   assign Busy            = (r_state != IDLE);
   assign Error           = r_error;
   assign Red_Exp         = r_red_exp;
   assign Green_Exp       = r_green_exp;
   assign Blue_Exp        = r_blue_exp;

endmodule

// File: tb/tb_bg_frame_scheduler.sv
// Bench for bg_frame_scheduler: a behavioural PE array raises its done flags a
// programmed number of cycles after each start pulse; each frame's expected
// outcome is queued when the frame is launched and checked by a monitor when
// Busy falls. Define BGS_WATCHDOG_EN for both files to include the watchdog case.
module tb_bg_frame_scheduler;

   localparam int NPE = 4;
   localparam int SW  = 16;
   localparam int TO  = 16;

   typedef int pe_arr_t [NPE];

   typedef struct {
      string nm;
      int    red, green, blue;
      int    done, err;
      int    n_ss, n_sb, n_ack;
      int    ack_lat, red_lat, fin_lat;
   } exp_t;

   logic              Clk = 1'b0;
   logic              Reset_n = 1'b0;
   logic              Go = 1'b0;
   logic              Skip_Sum = 1'b0;
   logic [NPE-1:0]    Pe_Qsd = '0;
   logic [NPE-1:0]    Pe_Qbgd = '0;
   logic [NPE*SW-1:0] Pe_Red_Sum = '0;
   logic [NPE*SW-1:0] Pe_Green_Sum = '0;
   logic [NPE*SW-1:0] Pe_Blue_Sum = '0;
   logic              Start_Sum, Start_BgRemoval, Ack, Busy, Done, Error;
   logic [7:0]        Red_Exp, Green_Exp, Blue_Exp;

   bg_frame_scheduler #(
      .NUM_PE(NPE), .LOG2_PIX(2), .SUM_W(SW), .TIMEOUT_CYC(TO)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Go(Go), .Skip_Sum(Skip_Sum),
      .Pe_Qsd(Pe_Qsd), .Pe_Qbgd(Pe_Qbgd),
      .Pe_Red_Sum(Pe_Red_Sum), .Pe_Green_Sum(Pe_Green_Sum), .Pe_Blue_Sum(Pe_Blue_Sum),
      .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval), .Ack(Ack),
      .Red_Exp(Red_Exp), .Green_Exp(Green_Exp), .Blue_Exp(Blue_Exp),
      .Busy(Busy), .Done(Done), .Error(Error)
   );

   always #5 Clk = ~Clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb_q[$];

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   function automatic exp_t mk(input string nm, input int r, input int g, input int b,
                               input int done, input int err, input int ss, input int sbg,
                               input int ack, input int al, input int rl, input int fl);
      exp_t e;
      e.nm = nm; e.red = r; e.green = g; e.blue = b; e.done = done; e.err = err;
      e.n_ss = ss; e.n_sb = sbg; e.n_ack = ack;
      e.ack_lat = al; e.red_lat = rl; e.fin_lat = fl;
      return e;
   endfunction

   // ---------------- behavioural PE array ----------------
   int s_dly[NPE];
   int b_dly[NPE];
   int p_cyc = 0;
   int s_t0 = 0;
   int b_t0 = 0;
   bit s_act = 1'b0;
   bit b_act = 1'b0;

   initial begin
      forever begin
         @(posedge Clk);
         #1;
         p_cyc++;
         if (!Reset_n) begin
            s_act = 1'b0;
            b_act = 1'b0;
         end else begin
            if (Start_Sum) begin s_act = 1'b1; s_t0 = p_cyc; end
            if (Start_BgRemoval) begin b_act = 1'b1; b_t0 = p_cyc; end
            if (Ack) begin s_act = 1'b0; b_act = 1'b0; end
         end
         for (int i = 0; i < NPE; i++) begin
            Pe_Qsd[i]  = s_act && ((p_cyc - s_t0) >= s_dly[i]);
            Pe_Qbgd[i] = b_act && ((p_cyc - b_t0) >= b_dly[i]);
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int m_cyc = 0;
   bit prev_busy = 1'b0;
   int c_ss = 0, c_sb = 0, c_ack = 0, c_multi = 0;
   int t_ss = 0, t_sb = 0, t_ack1 = 0, t_done = 0;
   bit saw_done = 1'b0;

   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #2;
         m_cyc++;
         if (Start_Sum) begin c_ss++; t_ss = m_cyc; end
         if (Start_BgRemoval) begin c_sb++; t_sb = m_cyc; end
         if (Ack) begin
            c_ack++;
            if (c_ack == 1) t_ack1 = m_cyc;
         end
         if ((int'(Start_Sum) + int'(Start_BgRemoval) + int'(Ack)) > 1) c_multi++;
         if (Done) begin saw_done = 1'b1; t_done = m_cyc; end
         if (prev_busy && !Busy) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_frame_end: got a frame end at cycle %0d, required none", m_cyc);
            end else begin
               e = sb_q.pop_front();
               chk({e.nm, "/done_seen"}, int'(saw_done), e.done);
               if (e.done != 0) chk({e.nm, "/done_in_last_busy_cycle"}, t_done, m_cyc - 1);
               chk({e.nm, "/red_exp"},   int'(Red_Exp),   e.red);
               chk({e.nm, "/green_exp"}, int'(Green_Exp), e.green);
               chk({e.nm, "/blue_exp"},  int'(Blue_Exp),  e.blue);
               chk({e.nm, "/error"},     int'(Error),     e.err);
               chk({e.nm, "/start_sum_pulses"}, c_ss,  e.n_ss);
               chk({e.nm, "/start_bg_pulses"},  c_sb,  e.n_sb);
               chk({e.nm, "/ack_pulses"},       c_ack, e.n_ack);
               chk({e.nm, "/overlapping_pulses"}, c_multi, 0);
               if (e.ack_lat >= 0) chk({e.nm, "/start_to_ack"}, t_ack1 - t_ss, e.ack_lat);
               if (e.red_lat >= 0) chk({e.nm, "/ack_to_bgstart"}, t_sb - t_ack1, e.red_lat);
               if (e.fin_lat >= 0) chk({e.nm, "/bgstart_to_end"}, (m_cyc - 1) - t_sb, e.fin_lat);
               $display("frame %s ended at cycle %0d: exp=%0d/%0d/%0d done=%0d err=%0d",
                        e.nm, m_cyc, Red_Exp, Green_Exp, Blue_Exp, saw_done, Error);
            end
            c_ss = 0; c_sb = 0; c_ack = 0; c_multi = 0; saw_done = 1'b0;
         end
         prev_busy = Busy;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic load(input pe_arr_t r, input pe_arr_t g, input pe_arr_t b,
                       input pe_arr_t sd, input pe_arr_t bd);
      for (int i = 0; i < NPE; i++) begin
         Pe_Red_Sum[i*SW +: SW]   = SW'(r[i]);
         Pe_Green_Sum[i*SW +: SW] = SW'(g[i]);
         Pe_Blue_Sum[i*SW +: SW]  = SW'(b[i]);
         s_dly[i] = sd[i];
         b_dly[i] = bd[i];
      end
   endtask

   task automatic launch(input bit skip, input exp_t e);
      sb_q.push_back(e);
      @(posedge Clk); #1;
      Go = 1'b1; Skip_Sum = skip;
      @(posedge Clk); #1;
      Go = 1'b0; Skip_Sum = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      for (k = 0; k < 300; k++) begin
         @(posedge Clk); #3;
         if (!Busy) break;
      end
      chk({nm, "/frame_terminates"}, int'(Busy), 0);
      repeat (2) @(posedge Clk);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      for (int i = 0; i < NPE; i++) begin s_dly[i] = 3; b_dly[i] = 3; end
      repeat (3) @(posedge Clk);
      #1;
      chk("reset/busy", int'(Busy), 0);
      chk("reset/done", int'(Done), 0);
      chk("reset/error", int'(Error), 0);
      chk("reset/pulses", int'(Start_Sum) + int'(Start_BgRemoval) + int'(Ack), 0);
      chk("reset/red_exp", int'(Red_Exp), 0);
      #3 Reset_n = 1'b1;
      repeat (2) @(posedge Clk);

      // full frame: 400/4=100, 40/4=10, 1020/4=255
      load('{40, 80, 120, 160}, '{4, 8, 12, 16}, '{0, 0, 0, 1020}, '{3, 3, 3, 3}, '{3, 3, 3, 3});
      launch(1'b0, mk("full", 100, 10, 255, 1, 0, 1, 1, 2, 4, 6, 5));
      wait_idle("full");

      // skip: held values reused, a Go during the frame is ignored
      load('{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{3, 3, 3, 3}, '{3, 3, 3, 3});
      launch(1'b1, mk("skip", 100, 10, 255, 1, 0, 0, 1, 1, -1, -1, 5));
      repeat (2) @(posedge Clk);
      #1 Go = 1'b1;
      @(posedge Clk); #1 Go = 1'b0;
      wait_idle("skip");

      // reset mid S_WAIT clears everything without waiting for a clock
      load('{1, 1, 1, 1}, '{1, 1, 1, 1}, '{1, 1, 1, 1}, '{50, 50, 50, 50}, '{3, 3, 3, 3});
      launch(1'b0, mk("midreset", 0, 0, 0, 0, 0, 1, 0, 0, -1, -1, -1));
      repeat (4) @(posedge Clk);
      #3;
      chk("midreset/busy_before", int'(Busy), 1);
      Reset_n = 1'b0;
      #1;
      chk("midreset/busy_async", int'(Busy), 0);
      chk("midreset/pulses_async", int'(Start_Sum) + int'(Start_BgRemoval) + int'(Ack) + int'(Done), 0);
      chk("midreset/red_exp_async", int'(Red_Exp), 0);
      chk("midreset/blue_exp_async", int'(Blue_Exp), 0);
      repeat (2) @(posedge Clk);
      #4 Reset_n = 1'b1;
      repeat (2) @(posedge Clk);

      // skip with nothing held since reset uses zeros
      load('{9, 9, 9, 9}, '{9, 9, 9, 9}, '{9, 9, 9, 9}, '{3, 3, 3, 3}, '{1, 1, 1, 1});
      launch(1'b1, mk("skip_cold", 0, 0, 0, 1, 0, 0, 1, 1, -1, -1, 3));
      wait_idle("skip_cold");

      // staggered SUM_DONE: last bit at 9 -> Ack 10 cycles after Start_Sum
      load('{10, 20, 30, 40}, '{255, 255, 255, 255}, '{3, 3, 3, 3}, '{2, 5, 5, 9}, '{3, 3, 3, 3});
      launch(1'b0, mk("stagger", 25, 255, 3, 1, 0, 1, 1, 2, 10, 6, 5));
      wait_idle("stagger");

      // saturation: 4*65535/4 = 65535 -> 255; 1000/4=250; 4/4=1
      load('{65535, 65535, 65535, 65535}, '{100, 200, 300, 400}, '{1, 1, 1, 1},
           '{1, 1, 1, 1}, '{2, 2, 2, 2});
      launch(1'b0, mk("saturate", 255, 250, 1, 1, 0, 1, 1, 2, 2, 6, 4));
      wait_idle("saturate");

`ifdef BGS_WATCHDOG_EN
      // stuck BG_DONE: timeout after 16 B_WAIT cycles, one extra Ack, no Done
      load('{4, 4, 4, 4}, '{0, 0, 0, 0}, '{8, 8, 8, 8}, '{3, 3, 3, 3}, '{1000, 1000, 1000, 1000});
      launch(1'b0, mk("watchdog", 4, 0, 8, 0, 1, 1, 1, 2, 4, 6, TO + 1));
      wait_idle("watchdog");

      // a sticky error does not prevent the next frame
      load('{40, 80, 120, 160}, '{4, 8, 12, 16}, '{0, 0, 0, 1020}, '{3, 3, 3, 3}, '{3, 3, 3, 3});
      launch(1'b0, mk("after_error", 100, 10, 255, 1, 1, 1, 1, 2, 4, 6, 5));
      wait_idle("after_error");
`endif

      chk("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // global time limit
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
      $fatal(1, "time limit");
   end

endmodule
